// File: rtl/rr_mux_array.sv
// Round-robin N:1 valid/ready mux with a registered output stage; optional packet lock via MUX_ARRAY_LOCK_EN.
// Latency: 1 cycle from input transfer to out_valid/out_data/out_sel.
// Backpressure: in_ready goes only to the granted channel, only when the output register is empty or draining.
module rr_mux_array #(
  parameter  int WIDTH    = 16,
  parameter  int CHANNELS = 4,
  localparam int SEL_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [CHANNELS-1:0]       in_valid,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
`ifdef MUX_ARRAY_LOCK_EN
  input  logic [CHANNELS-1:0]       in_last,
`endif
  output logic [CHANNELS-1:0]       in_ready,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_sel,
  input  logic                      out_ready
);

  // One extra bit so ptr + offset can be wrapped without overflow.
  localparam int IW = SEL_W + 1;
  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(CHANNELS - 1);

  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] gnt;
  logic             gnt_found;
  logic [SEL_W-1:0] rr_gnt;
  logic             rr_found;
  logic [IW-1:0]    idx;
  logic [SEL_W-1:0] next_ptr;
  logic             can_load;
  logic             xfer;
  logic [WIDTH-1:0] ch_data [CHANNELS];

`ifdef MUX_ARRAY_LOCK_EN
  logic             locked;
  logic [SEL_W-1:0] lock_ch;
`endif

  // Split the flat data bus into per-channel words.
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      ch_data[c] = in_data[c*WIDTH +: WIDTH];
    end
  end

  // Round-robin search: first valid channel at or after ptr, wrapping at CHANNELS.
  always_comb begin
    rr_found = 1'b0;
    rr_gnt   = '0;
    idx      = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      idx = {1'b0, ptr} + IW'(k);
      if (idx >= IW'(CHANNELS)) begin
        idx = idx - IW'(CHANNELS);
      end
      if (!rr_found && in_valid[idx[SEL_W-1:0]]) begin
        rr_found = 1'b1;
        rr_gnt   = idx[SEL_W-1:0];
      end
    end
  end

  // Final grant: a held lock overrides arbitration, even if the locked channel is idle.
  always_comb begin
    gnt       = rr_gnt;
    gnt_found = rr_found;
`ifdef MUX_ARRAY_LOCK_EN
    if (locked) begin
      gnt       = lock_ch;
      gnt_found = in_valid[lock_ch];
    end
`endif
  end

  assign can_load = !out_valid || out_ready;
  assign next_ptr = (gnt == LAST_CH) ? '0 : gnt + SEL_W'(1);

  // One-hot ready to the granted channel; forced low while reset is asserted.
  always_comb begin
    in_ready = '0;
    if (gnt_found && can_load && reset_n) begin
      in_ready[gnt] = 1'b1;
    end
  end

  assign xfer = |(in_valid & in_ready);

  // Output register, pointer and lock state; a drain without reload clears only out_valid.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= '0;
`ifdef MUX_ARRAY_LOCK_EN
      locked    <= 1'b0;
      lock_ch   <= '0;
`endif
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= ch_data[gnt];
      out_sel   <= gnt;
`ifdef MUX_ARRAY_LOCK_EN
      if (in_last[gnt]) begin
        locked <= 1'b0;
        ptr    <= next_ptr;
      end else begin
        locked  <= 1'b1;
        lock_ch <= gnt;
      end
`else
      ptr       <= next_ptr;
`endif
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_mux_array.sv
// Self-checking bench for rr_mux_array: directed scenarios plus randomized traffic against a cycle model.
// Inputs change on the falling edge; outputs and in_ready are sampled 1 time unit later.
// Producers hold valid/data until they see ready.
module tb_rr_mux_array;
  localparam int WIDTH    = 16;
  localparam int CHANNELS = 4;
  localparam int SEL_W    = 2;

  logic                      clk = 1'b0;
  logic                      reset_n;
  logic [CHANNELS-1:0]       in_valid;
  logic [CHANNELS*WIDTH-1:0] in_data;
  logic [CHANNELS-1:0]       in_last;
  logic [CHANNELS-1:0]       in_ready;
  logic                      out_valid;
  logic [WIDTH-1:0]          out_data;
  logic [SEL_W-1:0]          out_sel;
  logic                      out_ready;

  always #5 clk = ~clk;

  rr_mux_array #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
`ifdef MUX_ARRAY_LOCK_EN
    .in_last   (in_last),
`endif
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference state: what the output register should hold, plus arbitration pointer and lock.
  bit m_valid;
  int m_data, m_sel, m_ptr;
  bit m_lock;
  int m_lock_ch;

  // Stimulus applied on the next cycle.
  bit [CHANNELS-1:0] drv_valid, drv_last;
  logic [WIDTH-1:0]  drv_data [CHANNELS];
  bit                drv_ordy, drv_rst;
  bit [CHANNELS-1:0] acc;

  task automatic model_reset();
    m_valid = 0; m_data = 0; m_sel = 0; m_ptr = 0; m_lock = 0; m_lock_ch = 0;
  endtask

  // One clock: drive, compare against model, advance model, pass the rising edge.
  task automatic cycle();
    int g;
    bit can_load;
    logic [CHANNELS-1:0] exp_rdy;
    @(negedge clk);
    reset_n   = drv_rst;
    in_valid  = drv_valid;
    in_last   = drv_last;
    out_ready = drv_ordy;
    for (int i = 0; i < CHANNELS; i++) in_data[i*WIDTH +: WIDTH] = drv_data[i];
    #1;
    g = -1;
    if (m_lock) begin
      if (drv_valid[m_lock_ch]) g = m_lock_ch;
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        int i = (m_ptr + k) % CHANNELS;
        if (g < 0 && drv_valid[i]) g = i;
      end
    end
    can_load = !m_valid || drv_ordy;
    exp_rdy = '0;
    if (g >= 0 && can_load && drv_rst) exp_rdy[g] = 1'b1;
    check_eq("out_valid", 32'(out_valid), 32'(m_valid));
    check_eq("out_data",  32'(out_data),  m_data);
    check_eq("out_sel",   32'(out_sel),   m_sel);
    check_eq("in_ready",  32'(in_ready),  32'(exp_rdy));
    acc = drv_valid & in_ready;
    if (!drv_rst) begin
      model_reset();
    end else if (exp_rdy != '0) begin
      m_valid = 1;
      m_data  = int'(drv_data[g]);
      m_sel   = g;
`ifdef MUX_ARRAY_LOCK_EN
      if (drv_last[g]) begin
        m_lock = 0;
        m_ptr  = (g + 1) % CHANNELS;
      end else begin
        m_lock    = 1;
        m_lock_ch = g;
      end
`else
      m_ptr = (g + 1) % CHANNELS;
`endif
    end else if (m_valid && drv_ordy) begin
      m_valid = 0;
    end
    @(posedge clk);
  endtask

  bit [CHANNELS-1:0] pend;

  initial begin
    reset_n = 1'b0; in_valid = '0; in_data = '0; in_last = '1; out_ready = 1'b0;
    drv_last = '1; drv_ordy = 1'b1; drv_valid = '0; drv_rst = 1'b0;
    for (int i = 0; i < CHANNELS; i++) drv_data[i] = WIDTH'(16'hA000 | (i << 4));
    model_reset();
    repeat (2) @(posedge clk);

    // Reset held with all channels valid: nothing granted, outputs cleared.
    drv_rst = 0; drv_valid = '1;
    repeat (3) cycle();

    // Round-robin with everything valid: 0,1,2,3,... one beat per cycle.
    drv_rst = 1;
    for (int k = 0; k < 8; k++) begin
      cycle();
      #1;
      check_eq("rr_sel",  32'(out_sel),  k % CHANNELS);
      check_eq("rr_data", 32'(out_data), 32'(16'hA000 | ((k % CHANNELS) << 4)));
    end

    // Move ptr to 3 via a lone beat on channel 2, then only 0 and 3 valid: 3,0,3,0.
    drv_valid = 4'b0100;
    cycle();
    drv_valid = 4'b1001;
    for (int k = 0; k < 4; k++) begin
      cycle();
      #1;
      check_eq("wrap_sel", 32'(out_sel), (k % 2 == 0) ? 3 : 0);
    end

    // Backpressure: park 0x1234, stall 5 cycles, then replace with no bubble.
    drv_valid = 4'b0010; drv_data[1] = 16'h1234; drv_ordy = 1;
    cycle();
    drv_valid = 4'b0001; drv_data[0] = 16'h5555; drv_ordy = 0;
    for (int k = 0; k < 5; k++) begin
      cycle();
      #1;
      check_eq("bp_hold", 32'(out_data), 32'h1234);
      check_eq("bp_rdy",  32'(in_ready), 32'h0);
    end
    drv_ordy = 1;
    cycle();
    #1;
    check_eq("bp_valid", 32'(out_valid), 32'h1);
    check_eq("bp_repl",  32'(out_data),  32'h5555);

    // Reset while FULL and stalled: beat discarded, next grant restarts at channel 0.
    drv_ordy = 0; drv_valid = '1;
    cycle();
    drv_rst = 0;
    cycle();
    #1;
    check_eq("rst_mid_valid", 32'(out_valid), 32'h0);
    drv_rst = 1; drv_ordy = 1;
    cycle();
    #1;
    check_eq("rst_mid_sel", 32'(out_sel), 32'h0);

`ifdef MUX_ARRAY_LOCK_EN
    // Channel 2 sends a 3-beat burst while 0 and 1 compete: 2,2,2 then 0 then 1.
    drv_valid = 4'b0100; drv_last = 4'b1011;
    cycle();
    drv_valid = 4'b0111;
    cycle();
    drv_last = 4'b1111;
    cycle();
    drv_valid = 4'b0011;
    repeat (2) cycle();
`endif

    // Randomized traffic with occasional resets.
    pend = '0; drv_last = '1;
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (acc[i]) pend[i] = 0;
        if (!pend[i] && $urandom_range(0, 2) != 0) begin
          pend[i]     = 1;
          drv_data[i] = WIDTH'($urandom);
          drv_last[i] = ($urandom_range(0, 2) != 0);
        end
      end
      drv_valid = pend;
      drv_ordy  = ($urandom_range(0, 3) != 0);
      drv_rst   = ($urandom_range(0, 199) != 0);
      acc = '0;
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
